i2c_bus_arbiter_mux: RTL and testbench

- N-master arbiter and command multiplexer in front of the single shared i2c_master.
- Replaces the fixed two-slot arbiter and hand-written case mux in the OLED top levels.
- Lets init, map, score and sensor FSMs share one I2C bus.
- Grants are transaction-locked, selectable fixed or round-robin priority, and completion/error status is routed only to the current owner.

---
 rtl/i2c_bus_arbiter_mux.sv | 184 ++++++++++++++++++
 tb/tb_i2c_bus_arbiter_mux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter_mux.sv
// N-master arbiter and command mux in front of one shared i2c_master; grants are locked per transaction.
// Optional idle-owner watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter_mux #(
   parameter int N_MASTERS   = 4,
   parameter int DATA_W      = 8,
   parameter int RR_EN_MODE  = 1,
   parameter int TIMEOUT_CYC = 65535,
   localparam int IDW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [N_MASTERS-1:0]          req_i,
   input  logic [N_MASTERS-1:0]          m_start_i,
   input  logic [N_MASTERS-1:0]          m_stop_i,
   input  logic [N_MASTERS-1:0]          m_write_i,
   input  logic [N_MASTERS*DATA_W-1:0]   m_data_i,
   output logic [N_MASTERS-1:0]          grant_o,
   output logic [IDW-1:0]                owner_id_o,
   output logic [N_MASTERS-1:0]          m_done_o,
   output logic [N_MASTERS-1:0]          m_ack_err_o,
   output logic                          bus_busy_o,
   input  logic                          i2c_done_i,
   input  logic                          i2c_busy_i,
   input  logic                          i2c_ack_err_i,
   output logic                          i2c_start_o,
   output logic                          i2c_stop_o,
   output logic                          i2c_write_o,
   output logic [DATA_W-1:0]             i2c_data_o,
   output logic                          timeout_err_o,
   output logic [1:0]                    state_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
      $error("i2c_bus_arbiter_mux: N_MASTERS must be 2..8 and TIMEOUT_CYC >= 1");
   end

   state_e                 state_q, state_d;
   logic [N_MASTERS-1:0]   grant_q, grant_d;
   logic [IDW-1:0]         owner_q, owner_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [N_MASTERS-1:0]   eff_req;
   logic [2*N_MASTERS-1:0] rot_req;
   logic                   win_found;
   int                     win_pos;
   int                     win_idx;
   logic                   owner_req;
   logic                   owner_strobe;
   logic                   timeout_hit;

   assign owner_req    = |(grant_q & req_i);
   assign owner_strobe = |(grant_q & (m_start_i | m_stop_i | m_write_i));

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [N_MASTERS-1:0] mask_q, mask_d;
   logic                 to_q, to_d;

   assign eff_req       = req_i & ~mask_q;
   assign timeout_hit   = (state_q == ST_GRANT) && !owner_strobe && !i2c_busy_i &&
                          (cnt_q == CW'(TIMEOUT_CYC - 1));
   assign timeout_err_o = to_q;

   // A revoked master stays masked until it lets go of req at least once.
   always_comb begin
      cnt_d  = '0;
      mask_d = mask_q & req_i;
      to_d   = 1'b0;
      if (state_q == ST_GRANT && !owner_strobe && !i2c_busy_i) cnt_d = cnt_q + CW'(1);
      if (timeout_hit && owner_req) begin
         cnt_d  = '0;
         mask_d = mask_d | grant_q;
         to_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         mask_q <= '0;
         to_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mask_q <= mask_d;
         to_q   <= to_d;
      end
   end
`else
   assign eff_req       = req_i;
   assign timeout_hit   = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   // Rotated view puts master (ptr+1) at bit 0 so round-robin reduces to a lowest-bit search.
   assign rot_req = {eff_req, eff_req} >> (int'(rr_ptr_q) + 1);

   always_comb begin
      win_found = 1'b0;
      win_pos   = 0;
      win_idx   = 0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (RR_EN_MODE != 0) begin
            if (rot_req[i]) begin
               win_found = 1'b1;
               win_pos   = i;
            end
         end else if (eff_req[i]) begin
            win_found = 1'b1;
            win_pos   = i;
         end
      end
      if (RR_EN_MODE != 0) begin
         win_idx = int'(rr_ptr_q) + 1 + win_pos;
         if (win_idx >= N_MASTERS) win_idx = win_idx - N_MASTERS;
      end else begin
         win_idx = win_pos;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found && !i2c_busy_i) begin
               state_d = ST_GRANT;
               grant_d = N_MASTERS'(1) << win_idx;
               owner_d = IDW'(win_idx);
            end
         end
         ST_GRANT: begin
            // Owner release waits for i2c_busy to fall so a byte in flight is never cut.
            if ((!owner_req && !i2c_busy_i) || timeout_hit) begin
               state_d  = ST_RELEASE;
               grant_d  = '0;
               owner_d  = '0;
               rr_ptr_d = owner_q;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         owner_q  <= '0;
         rr_ptr_q <= IDW'(N_MASTERS - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      i2c_data_o = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         if (grant_q[k]) i2c_data_o = m_data_i[k*DATA_W +: DATA_W];
      end
   end

   assign i2c_start_o = |(grant_q & m_start_i);
   assign i2c_stop_o  = |(grant_q & m_stop_i);
   assign i2c_write_o = |(grant_q & m_write_i);
   assign m_done_o    = grant_q & {N_MASTERS{i2c_done_i}};
   assign m_ack_err_o = grant_q & {N_MASTERS{i2c_ack_err_i}};
   assign grant_o     = grant_q;
   assign owner_id_o  = owner_q;
   assign bus_busy_o  = (state_q != ST_IDLE) | i2c_busy_i;
   assign state_o     = state_q;

endmodule

// File: tb/tb_i2c_bus_arbiter_mux.sv
// Directed bench for i2c_bus_arbiter_mux: one round-robin and one fixed-priority instance share stimulus.
module tb_i2c_bus_arbiter_mux;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 65535;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, m_start, m_stop, m_write;
  logic [31:0] m_data;
  logic i2c_done, i2c_busy, i2c_ack_err;

  logic [3:0] grant_r, done_r, ackerr_r, grant_f, done_f, ackerr_f;
  logic [1:0] owner_r, owner_f, state_r, state_f;
  logic busy_r, start_r, stop_r, write_r, to_r;
  logic busy_f, start_f, stop_f, write_f, to_f;
  logic [7:0] data_r, data_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter_mux #(.N_MASTERS(4), .DATA_W(8), .RR_EN_MODE(1), .TIMEOUT_CYC(TO_CYC)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .m_start_i(m_start), .m_stop_i(m_stop),
    .m_write_i(m_write), .m_data_i(m_data), .grant_o(grant_r), .owner_id_o(owner_r),
    .m_done_o(done_r), .m_ack_err_o(ackerr_r), .bus_busy_o(busy_r), .i2c_done_i(i2c_done),
    .i2c_busy_i(i2c_busy), .i2c_ack_err_i(i2c_ack_err), .i2c_start_o(start_r),
    .i2c_stop_o(stop_r), .i2c_write_o(write_r), .i2c_data_o(data_r),
    .timeout_err_o(to_r), .state_o(state_r));

  i2c_bus_arbiter_mux #(.N_MASTERS(4), .DATA_W(8), .RR_EN_MODE(0), .TIMEOUT_CYC(TO_CYC)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .m_start_i(m_start), .m_stop_i(m_stop),
    .m_write_i(m_write), .m_data_i(m_data), .grant_o(grant_f), .owner_id_o(owner_f),
    .m_done_o(done_f), .m_ack_err_o(ackerr_f), .bus_busy_o(busy_f), .i2c_done_i(i2c_done),
    .i2c_busy_i(i2c_busy), .i2c_ack_err_i(i2c_ack_err), .i2c_start_o(start_f),
    .i2c_stop_o(stop_f), .i2c_write_o(write_f), .i2c_data_o(data_f),
    .timeout_err_o(to_f), .state_o(state_f));

  // Returns 1 ns after a rising edge, so registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; m_start = '0; m_stop = '0; m_write = '0; m_data = '0;
    i2c_done = 1'b0; i2c_busy = 1'b0; i2c_ack_err = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    req = 4'b1111; m_start = 4'b1111;
    step(); step();
    vectors++; if (grant_f !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got %b want 0000", grant_f); end
    vectors++; if (start_f !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", start_f); end
    vectors++; if (owner_r !== 2'd0 || to_f !== 1'b0 || busy_r !== 1'b0) begin
      miscompares++; $display("FAIL reset_misc owner=%0d to=%b busy=%b want 0 0 0", owner_r, to_f, busy_r); end
    rst_n = 1'b1;
    step();
    vectors++; if (grant_f !== 4'b0001 || owner_f !== 2'd0) begin
      miscompares++; $display("FAIL reset_first_grant_fix got %b/%0d want 0001/0", grant_f, owner_f); end
    vectors++; if (grant_r !== 4'b0001 || owner_r !== 2'd0) begin
      miscompares++; $display("FAIL reset_first_grant_rr got %b/%0d want 0001/0", grant_r, owner_r); end
    vectors++; if (start_f !== 1'b1) begin miscompares++; $display("FAIL owner_start got %b want 1", start_f); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      vectors++; if (grant_r !== exp_g || owner_r !== 2'(k % 4)) begin
        miscompares++; $display("FAIL rr_grant[%0d] got %b/%0d want %b/%0d", k, grant_r, owner_r, exp_g, k % 4); end
      if (k == 4) break;
      i2c_done = 1'b1;
      #1;
      vectors++; if (done_r !== exp_g) begin
        miscompares++; $display("FAIL rr_done[%0d] got %b want %b", k, done_r, exp_g); end
      step();
      i2c_done = 1'b0;
      req[k % 4] = 1'b0;
      step();
      req[k % 4] = 1'b1;
      vectors++; if (grant_r !== 4'b0000 || state_r !== 2'd2) begin
        miscompares++; $display("FAIL rr_release[%0d] got %b/st%0d want 0000/st2", k, grant_r, state_r); end
      step();
      vectors++; if (grant_r !== 4'b0000 || state_r !== 2'd0) begin
        miscompares++; $display("FAIL rr_idle[%0d] got %b/st%0d want 0000/st0", k, grant_r, state_r); end
      step();
    end
  endtask

  task automatic test_fixed_mux();
    do_reset();
    req = 4'b1010;
    m_data = 32'hFF00_7800; m_write = 4'b1010; m_start = 4'b1000;
    step();
    vectors++; if (grant_f !== 4'b0010 || owner_f !== 2'd1) begin
      miscompares++; $display("FAIL fix_grant got %b/%0d want 0010/1", grant_f, owner_f); end
    vectors++; if (data_f !== 8'h78 || write_f !== 1'b1) begin
      miscompares++; $display("FAIL fix_data got %h/%b want 78/1", data_f, write_f); end
    vectors++; if (start_f !== 1'b0) begin
      miscompares++; $display("FAIL fix_nonowner_start got %b want 0", start_f); end
    i2c_ack_err = 1'b1;
    #1;
    vectors++; if (ackerr_f !== 4'b0010) begin
      miscompares++; $display("FAIL fix_ack_err got %b want 0010", ackerr_f); end
    i2c_ack_err = 1'b0;
    req = 4'b1000;
    step();
    vectors++; if (grant_f !== 4'b0000 || data_f !== 8'h00 || write_f !== 1'b0 || start_f !== 1'b0) begin
      miscompares++; $display("FAIL fix_guard got %b/%h/%b/%b want 0000/00/0/0", grant_f, data_f, write_f, start_f); end
    step();
    vectors++; if (grant_f !== 4'b0000 || busy_f !== 1'b0) begin
      miscompares++; $display("FAIL fix_idle got %b/busy%b want 0000/0", grant_f, busy_f); end
    step();
    vectors++; if (grant_f !== 4'b1000 || owner_f !== 2'd3 || data_f !== 8'hFF || start_f !== 1'b1) begin
      miscompares++; $display("FAIL fix_second got %b/%0d/%h/%b want 1000/3/ff/1", grant_f, owner_f, data_f, start_f); end
    req = 4'b1001;
    step(); step();
    vectors++; if (grant_f !== 4'b1000) begin
      miscompares++; $display("FAIL fix_no_preempt got %b want 1000", grant_f); end
    req = 4'b0001;
    step(); step(); step();
    vectors++; if (grant_f !== 4'b0001) begin
      miscompares++; $display("FAIL fix_after_preempt got %b want 0001", grant_f); end
  endtask

  task automatic test_busy_hold();
    do_reset();
    req = 4'b0100;
    step();
    vectors++; if (grant_f !== 4'b0100) begin
      miscompares++; $display("FAIL hold_grant got %b want 0100", grant_f); end
    i2c_busy = 1'b1;
    req = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++; if (grant_f !== 4'b0100 || busy_f !== 1'b1) begin
        miscompares++; $display("FAIL hold_cycle[%0d] got %b/busy%b want 0100/1", c, grant_f, busy_f); end
      if (c == 4) begin
        i2c_done = 1'b1;
        #1;
        vectors++; if (done_f !== 4'b0100) begin
          miscompares++; $display("FAIL hold_done got %b want 0100", done_f); end
        i2c_done = 1'b0;
      end
    end
    i2c_busy = 1'b0;
    step();
    vectors++; if (grant_f !== 4'b0000 || state_f !== 2'd2) begin
      miscompares++; $display("FAIL hold_release got %b/st%0d want 0000/st2", grant_f, state_f); end
  endtask

  task automatic test_idle_busy();
    do_reset();
    i2c_busy = 1'b1;
    req = 4'b0001;
    step(); step();
    vectors++; if (grant_f !== 4'b0000 || busy_f !== 1'b1) begin
      miscompares++; $display("FAIL drain_no_grant got %b/busy%b want 0000/1", grant_f, busy_f); end
    i2c_busy = 1'b0;
    step();
    vectors++; if (grant_f !== 4'b0001) begin
      miscompares++; $display("FAIL drain_then_grant got %b want 0001", grant_f); end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    step();
`ifdef I2C_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      step();
      vectors++; if (grant_f !== 4'b0001 || to_f !== 1'b0) begin
        miscompares++; $display("FAIL to_hold[%0d] got %b/to%b want 0001/0", c, grant_f, to_f); end
    end
    step();
    vectors++; if (grant_f !== 4'b0000 || to_f !== 1'b1) begin
      miscompares++; $display("FAIL to_fire got %b/to%b want 0000/1", grant_f, to_f); end
    step();
    vectors++; if (to_f !== 1'b0) begin miscompares++; $display("FAIL to_pulse got %b want 0", to_f); end
    step();
    vectors++; if (grant_f !== 4'b0010) begin
      miscompares++; $display("FAIL to_next_owner got %b want 0010", grant_f); end
    req = 4'b0001;
    step(); step(); step();
    vectors++; if (grant_f !== 4'b0000) begin
      miscompares++; $display("FAIL to_masked got %b want 0000", grant_f); end
    req = 4'b0000;
    step();
    req = 4'b0001;
    step();
    vectors++; if (grant_f !== 4'b0001) begin
      miscompares++; $display("FAIL to_unmasked got %b want 0001", grant_f); end
`else
    for (int c = 0; c < 20; c++) step();
    vectors++; if (grant_f !== 4'b0001 || to_f !== 1'b0) begin
      miscompares++; $display("FAIL no_watchdog got %b/to%b want 0001/0", grant_f, to_f); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_fixed_mux();
    test_busy_hold();
    test_idle_busy();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
